// File: rtl/miss_arbiter.sv
// miss_arbiter: round-robin cache-miss arbiter onto one memory port; define MISS_ARBITER_PERF_EN for perf counters
module miss_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQUESTERS-1:0]           req_read_valid,
    input  logic [NUM_REQUESTERS*ADDR_BITS-1:0] req_read_address,
    output logic [NUM_REQUESTERS-1:0]           req_read_ready,
    output logic [NUM_REQUESTERS*DATA_BITS-1:0] req_read_data,
    input  logic [NUM_REQUESTERS-1:0]           req_write_valid,
    input  logic [NUM_REQUESTERS*ADDR_BITS-1:0] req_write_address,
    input  logic [NUM_REQUESTERS*DATA_BITS-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]           req_write_ready,
    output logic                                mem_read_valid,
    output logic [ADDR_BITS-1:0]                mem_read_address,
    input  logic                                mem_read_ready,
    input  logic [DATA_BITS-1:0]                mem_read_data,
    output logic                                mem_write_valid,
    output logic [ADDR_BITS-1:0]                mem_write_address,
    output logic [DATA_BITS-1:0]                mem_write_data,
    input  logic                                mem_write_ready,
    output logic                                busy,
    output logic [15:0]                         perf_grants,
    output logic [15:0]                         perf_wait_cycles
);
    localparam int IW = NUM_REQUESTERS > 1 ? $clog2(NUM_REQUESTERS) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE_WRITE, ISSUE_READ, RESPOND, WAIT_DROP} state_t;
    state_t state;
    logic [IW-1:0] rr_ptr, g, pick, cand;
    logic found, wr;
    logic [NUM_REQUESTERS-1:0] pend, g_hot;
    logic [ADDR_BITS-1:0] wa, ra;
    logic [DATA_BITS-1:0] wd;
    assign pend = req_read_valid | req_write_valid;
    assign g_hot = NUM_REQUESTERS'(1) << g;
    // scan from the highest offset down so the nearest pending index at or after rr_ptr wins
    always_comb begin
        found = 1'b0;
        pick = '0;
        cand = '0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQUESTERS);
            if (pend[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end
    always_comb begin
        wa = '0;
        ra = '0;
        wd = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (IW'(i) == pick) begin
                wa = req_write_address[i*ADDR_BITS +: ADDR_BITS];
                ra = req_read_address[i*ADDR_BITS +: ADDR_BITS];
                wd = req_write_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            g <= '0;
            wr <= 1'b0;
            busy <= 1'b0;
            mem_read_valid <= 1'b0;
            mem_read_address <= '0;
            mem_write_valid <= 1'b0;
            mem_write_address <= '0;
            mem_write_data <= '0;
            req_read_ready <= '0;
            req_write_ready <= '0;
            req_read_data <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    g <= pick;
                    rr_ptr <= (pick == IW'(NUM_REQUESTERS - 1)) ? '0 : pick + 1'b1;
                    busy <= 1'b1;
                    wr <= req_write_valid[pick];
                    if (req_write_valid[pick]) begin
                        state <= ISSUE_WRITE;
                        mem_write_valid <= 1'b1;
                        mem_write_address <= wa;
                        mem_write_data <= wd;
                    end else begin
                        state <= ISSUE_READ;
                        mem_read_valid <= 1'b1;
                        mem_read_address <= ra;
                    end
                end
                ISSUE_WRITE: if (mem_write_ready) begin
                    mem_write_valid <= 1'b0;
                    req_write_ready <= g_hot;
                    state <= RESPOND;
                end
                ISSUE_READ: if (mem_read_ready) begin
                    mem_read_valid <= 1'b0;
                    req_read_ready <= g_hot;
                    state <= RESPOND;
                    for (int i = 0; i < NUM_REQUESTERS; i++)
                        if (IW'(i) == g) req_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                end
                RESPOND: begin
                    req_read_ready <= '0;
                    req_write_ready <= '0;
                    state <= WAIT_DROP;
                end
                WAIT_DROP: if (!(wr ? req_write_valid[g] : req_read_valid[g])) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MISS_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (state == IDLE && found && perf_grants != 16'hFFFF)
                perf_grants <= perf_grants + 1'b1;
            if (((state == ISSUE_WRITE && !mem_write_ready) || (state == ISSUE_READ && !mem_read_ready))
                && perf_wait_cycles != 16'hFFFF)
                perf_wait_cycles <= perf_wait_cycles + 1'b1;
        end
    end
`else
    assign perf_grants = '0;
    assign perf_wait_cycles = '0;
`endif
endmodule

// File: doc/miss_arbiter.md
MISS_ARBITER -- requirements
Module: miss_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, byte-address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, data word width.
REQ-003 SHALL have parameter NUM_REQUESTERS, default 4, number of cache miss ports arbitrated, range 1..16.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_read_valid  in  NUM_REQUESTERS  per-requester fill request.
- req_read_address  in  NUM_REQUESTERS*ADDR_BITS  fill address, requester i at bits [i*ADDR_BITS +: ADDR_BITS].
- req_read_ready  out  NUM_REQUESTERS  fill complete.
- req_read_data  out  NUM_REQUESTERS*DATA_BITS  fill data, same packing.
- req_write_valid  in  NUM_REQUESTERS  per-requester writeback request.
- req_write_address  in  NUM_REQUESTERS*ADDR_BITS  writeback address.
- req_write_data  in  NUM_REQUESTERS*DATA_BITS  writeback data.
- req_write_ready  out  NUM_REQUESTERS  writeback accepted.
- mem_read_valid  out  1  read request to memory controller.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  read data valid.
- mem_read_data  in  DATA_BITS  read data.
- mem_write_valid  out  1  write request to memory controller.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  write accepted.
- busy  out  1  high in every state except IDLE.
- perf_grants  out  16  grant counter (REQ-020).
- perf_wait_cycles  out  16  memory-wait counter (REQ-020).

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE_WRITE, ISSUE_READ, RESPOND, WAIT_DROP; all outputs registered.
REQ-006 IDLE: requester i is pending if req_write_valid[i] or req_read_valid[i]; SHALL grant the first pending index at or after rr_ptr, wrapping NUM_REQUESTERS-1 -> 0; grant, latched address and latched data registered on the same edge.
REQ-007 On grant SHALL set rr_ptr = (granted+1) mod NUM_REQUESTERS; no pending requester -> stay IDLE, rr_ptr unchanged.
REQ-008 Write priority within requester: if granted requester has write valid (read valid or not), enter ISSUE_WRITE; otherwise ISSUE_READ.
REQ-009 ISSUE_WRITE: mem_write_valid=1 with latched address/data until mem_write_ready sampled high; then drop mem_write_valid next edge and enter RESPOND.
REQ-010 ISSUE_READ: mem_read_valid=1 with latched address until mem_read_ready sampled high; latch mem_read_data on that edge, drop mem_read_valid, enter RESPOND.
REQ-011 RESPOND: exactly one-cycle pulse of req_write_ready[g] or req_read_ready[g] for granted g; req_read_data[g] holds latched fill data from this cycle until the next fill to g; then WAIT_DROP.
REQ-012 WAIT_DROP: remain until the completed valid of g is low, then IDLE; a still-high other valid of g (read after writeback) is then arbitrated normally.
REQ-013 Minimum latency, request to ready, with mem ready returned the first cycle valid is seen: 3 cycles (grant, issue, respond).
REQ-014 Never assert mem_read_valid and mem_write_valid simultaneously; never more than one ready bit high.
REQ-015 Requester valid dropped while granted SHALL NOT abort the memory transaction; it completes and the ready pulse is still issued.
REQ-016 Inputs from non-granted requesters SHALL be ignored until IDLE.

Reset
REQ-017 Reset SHALL force state IDLE, rr_ptr=0, busy=0, all valids/readies 0, mem address/data 0, req_read_data 0, perf counters 0.
REQ-018 Reset mid-transaction SHALL abandon it without ready pulse; mem valids low on the cycle after reset is sampled.

Configuration
REQ-019 Macro MISS_ARBITER_PERF_EN SHALL control performance counters.
REQ-020 With it defined: perf_grants increments per grant, perf_wait_cycles increments each cycle in ISSUE_* with mem ready low; both saturate at 16'hFFFF. Without it: both ports constant 0, no counter flops.

Verification
REQ-021 Requester 2 read 0x40, mem ready after 2 cycles with data 0xA5 -> req_read_ready[2] single pulse, req_read_data[2]=0xA5, mem_read_address=0x40.
REQ-022 All 4 requesters read simultaneously, held until ready -> grant order 0,1,2,3; then new request from 0 and 3 together -> 0 first.
REQ-023 Requester 1 write 0x10/0x3C and read 0x20 together -> mem write 0x10 data 0x3C completes before any mem read; read served only after write ready dropped.
REQ-024 Reset asserted while ISSUE_READ waits -> next cycle mem_read_valid=0, busy=0, no ready pulse.
REQ-025 With MISS_ARBITER_PERF_EN, three reads each waiting 4 cycles -> perf_grants=3, perf_wait_cycles=12; without macro both read 0.
